tracking_axi_lite_regs: RTL and testbench
=========================================

// Module: tracking_axi_lite_regs
// PURPOSE
//  AXI4-Lite slave register file of the Tracking IP; directly downstream of the S00_AXI AXI4-Lite master.
//  Holds 4 RW control words that drive the tracking core, plus RO status words the core reports back.
//  AW and W channels are buffered independently. Write and read paths run concurrently.
// PARAMETERS
//  C_S_AXI_DATA_WIDTH  32  data bus width; only 32 is supported
//  C_S_AXI_ADDR_WIDTH  5   byte address width; 8 word slots, word index = ADDR[4:2]
// PORTS
//  S_AXI_ACLK     in   1   clock; single clock domain
//  S_AXI_ARESETN  in   1   reset, asynchronous, active-low
//  S_AXI_AWADDR   in   5   write address; AWPROT is accepted and ignored
//  S_AXI_AWVALID/S_AXI_AWREADY   in/out  1  write-address handshake
//  S_AXI_WDATA    in   32  write data
//  S_AXI_WSTRB    in   4   byte enables
//  S_AXI_WVALID/S_AXI_WREADY     in/out  1  write-data handshake
//  S_AXI_BRESP    out  2   00 OKAY, 10 SLVERR
//  S_AXI_BVALID/S_AXI_BREADY     out/in  1  write-response handshake
//  S_AXI_ARADDR   in   5   read address; ARPROT is accepted and ignored
//  S_AXI_ARVALID/S_AXI_ARREADY   in/out  1  read-address handshake
//  S_AXI_RDATA    out  32  read data
//  S_AXI_RRESP    out  2   00 OKAY, 10 SLVERR
//  S_AXI_RVALID/S_AXI_RREADY     out/in  1  read-data handshake
//  ctrl0_o..ctrl3_o  out  32 each  RW registers at 0x00/0x04/0x08/0x0C
//  wr_stb_o       out  4   one-cycle pulse, bit i set when ctrl i is written
//  pos_x_i, pos_y_i  in  16 each  tracked position, read at 0x10 as {pos_y_i,pos_x_i}
//  frame_cnt_i    in   32  frame counter, read at 0x14
// BEHAVIOUR
//  Reset (async, ARESETN low): ctrl0..3=0, wr_stb_o=0, BVALID=RVALID=0, BRESP=RRESP=00, RDATA=0.
//   AWREADY, WREADY and ARREADY are 0 while in reset and 1 in the first cycle after reset release.
//   A reset during a transaction discards all buffered AW/W and any pending B or R; no register is updated.
//  Address map (word index): 0-3 ctrl RW; 4 position RO; 5 frame_cnt RO; 6-7 unmapped.
//  Write path:
//   - AW buffer: AWREADY=1 when the buffer is empty and BVALID=0; AWADDR is captured on handshake.
//   - W buffer: WREADY=1 when the buffer is empty and BVALID=0; WDATA and WSTRB are captured on handshake.
//   - AW may precede W and W may precede AW, by any number of cycles.
//   - Commit edge: the first edge where both AW and W are available, either buffered or handshaking that edge.
//   - Same-cycle AW+W therefore commits at that edge.
//   - Commit to index 0-3: byte lanes with WSTRB[k]=1 are updated, others are held.
//     wr_stb_o[i] pulses in the next cycle even when WSTRB=0. BRESP=OKAY.
//   - Commit to index 4-7: no state change, BRESP=SLVERR.
//   - BVALID rises in the cycle after commit and holds, with BRESP stable, until the BREADY handshake.
//     Both buffers are freed at commit. New AW/W are accepted only after BVALID drops.
//     So a BREADY-tied-high master sees a 2-cycle write issue rate.
//  Read path:
//   - ARREADY = !RVALID.
//   - On an AR handshake at edge N, RDATA/RRESP are registered at edge N and RVALID=1 from N+1.
//     RDATA/RRESP hold until the RREADY handshake, then RVALID=0 and ARREADY=1 the next cycle.
//   - Index 0-3: ctrl value; 4/5: inputs sampled at edge N; 6-7: RDATA=0 with RRESP=SLVERR. RRESP=OKAY otherwise.
//  Simultaneous events:
//   - A read and a write commit on the same edge to the same ctrl register: the read returns the OLD value.
//   - Write and read FSMs are independent; neither stalls the other.
//  Read FSM states: R_IDLE (ARREADY=1) -> R_DATA on AR handshake; R_DATA -> R_IDLE on RREADY.
//  Write FSM states:
//   - W_IDLE -> W_HAVE_AW or W_HAVE_W on a one-sided handshake; -> W_RESP on commit.
//   - W_HAVE_* -> W_RESP when the missing half arrives.
//   - W_RESP -> W_IDLE on BREADY.
//  Address bits [1:0] are ignored.
// TESTING
//  1 Write 0x0101FFFF,0xABCD0001,0xDEAD0011,0xBEEF0011 to 0x00,0x04,0x08,0x0C, each read back
//    -> every data word matches; all BRESP/RRESP=00; wr_stb_o pulses 0001,0010,0100,1000.
//  2 W leads AW by 3 cycles (0x12345678 to 0x08), then AW leads W by 3 cycles (0x0 to 0x0C)
//    -> single BVALID per write; ctrl2=0x12345678, ctrl3=0.
//  3 ctrl1=0xFFFFFFFF, then write 0x00000000 with WSTRB=0101 -> ctrl1=0xFF00FF00.
//  4 pos_x_i=0x0040, pos_y_i=0x0020, frame_cnt_i=7: read 0x10 -> 0x00200040 OKAY; read 0x14 -> 7 OKAY;
//    write 0x10 -> SLVERR, no change; read 0x18 -> 0, SLVERR.
//  5 BREADY/RREADY held low 10 cycles -> BVALID/RVALID, BRESP/RDATA stable; AWREADY/WREADY/ARREADY stay 0.
//  6 ARESETN pulsed low mid-write (AW buffered, W pending) -> all outputs at reset values; ctrl unchanged=0;
//    next full write completes normally.

Source files
------------

// File: rtl/tracking_axi_lite_regs.sv
// AXI4-Lite register file for the Tracking IP: four RW control words driving the core
// and RO position/frame status words, with independent AW/W buffering and concurrent read path.
module tracking_axi_lite_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     ctrl0_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     ctrl1_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     ctrl2_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     ctrl3_o,
  output logic [3:0]                        wr_stb_o,
  input  logic [15:0]                       pos_x_i,
  input  logic [15:0]                       pos_y_i,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     frame_cnt_i
);

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_HAVE_AW = 2'd1,
    W_HAVE_W  = 2'd2,
    W_RESP    = 2'd3
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int k = 0; k < 4; k++) begin
      if (strb[k]) begin
        res[8*k +: 8] = new_val[8*k +: 8];
      end else begin
        res[8*k +: 8] = old_val[8*k +: 8];
      end
    end
    return res;
  endfunction

  w_state_t    r_w_state;
  w_state_t    w_w_next;
  logic [2:0]  r_aw_idx;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_awready;
  logic        r_wready;
  logic        r_bvalid;
  logic [1:0]  r_bresp;
  logic [3:0]  r_wr_stb;
  logic [31:0] r_ctrl [4];

  r_state_t    r_r_state;
  logic        r_arready;
  logic        r_rvalid;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;

  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_ar_hs;
  logic        w_commit;
  logic [2:0]  w_widx;
  logic [31:0] w_wdata;
  logic [3:0]  w_wstrb;
  logic [31:0] w_rd_data;
  logic [1:0]  w_rd_resp;
  logic        w_unused;

  assign w_aw_hs  = S_AXI_AWVALID & r_awready;
  assign w_w_hs   = S_AXI_WVALID & r_wready;
  assign w_ar_hs  = S_AXI_ARVALID & r_arready;
  // A half is available when it is buffered or handshaking on this very edge.
  assign w_commit = (w_aw_hs | (r_w_state == W_HAVE_AW)) & (w_w_hs | (r_w_state == W_HAVE_W));
  assign w_widx   = (r_w_state == W_HAVE_AW) ? r_aw_idx : S_AXI_AWADDR[4:2];
  assign w_wdata  = (r_w_state == W_HAVE_W) ? r_wdata : S_AXI_WDATA;
  assign w_wstrb  = (r_w_state == W_HAVE_W) ? r_wstrb : S_AXI_WSTRB;
  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Write FSM next-state decode.
  always_comb begin
    w_w_next = r_w_state;
    case (r_w_state)
      W_IDLE: begin
        if (w_commit) begin
          w_w_next = W_RESP;
        end else if (w_aw_hs) begin
          w_w_next = W_HAVE_AW;
        end else if (w_w_hs) begin
          w_w_next = W_HAVE_W;
        end else begin
          w_w_next = W_IDLE;
        end
      end
      W_HAVE_AW, W_HAVE_W: begin
        if (w_commit) begin
          w_w_next = W_RESP;
        end else begin
          w_w_next = r_w_state;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          w_w_next = W_IDLE;
        end else begin
          w_w_next = W_RESP;
        end
      end
      default: w_w_next = W_IDLE;
    endcase
  end

  // Write path registers, control words and strobes.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_w_state <= W_IDLE;
      r_aw_idx  <= 3'd0;
      r_wdata   <= 32'd0;
      r_wstrb   <= 4'd0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_wr_stb  <= 4'd0;
      for (int i = 0; i < 4; i++) begin
        r_ctrl[i] <= 32'd0;
      end
    end else begin
      r_w_state <= w_w_next;
      r_awready <= (w_w_next == W_IDLE) | (w_w_next == W_HAVE_W);
      r_wready  <= (w_w_next == W_IDLE) | (w_w_next == W_HAVE_AW);
      r_wr_stb  <= 4'd0;
      if (w_aw_hs) begin
        r_aw_idx <= S_AXI_AWADDR[4:2];
      end
      if (w_w_hs) begin
        r_wdata <= S_AXI_WDATA;
        r_wstrb <= S_AXI_WSTRB;
      end
      if (w_commit) begin
        r_bvalid <= 1'b1;
        if (!w_widx[2]) begin
          r_ctrl[w_widx[1:0]] <= merge_bytes(r_ctrl[w_widx[1:0]], w_wdata, w_wstrb);
          r_wr_stb            <= 4'b0001 << w_widx[1:0];
          r_bresp             <= RESP_OKAY;
        end else begin
          r_bresp <= RESP_SLVERR;
        end
      end else if (r_bvalid && S_AXI_BREADY) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  // Read data mux; uses current control values so a same-edge write is not visible.
  always_comb begin
    w_rd_data = 32'd0;
    w_rd_resp = RESP_OKAY;
    case (S_AXI_ARADDR[4:2])
      3'd0, 3'd1, 3'd2, 3'd3: w_rd_data = r_ctrl[S_AXI_ARADDR[3:2]];
      3'd4:    w_rd_data = {pos_y_i, pos_x_i};
      3'd5:    w_rd_data = frame_cnt_i;
      default: begin
        w_rd_data = 32'd0;
        w_rd_resp = RESP_SLVERR;
      end
    endcase
  end

  // Read FSM with registered handshake outputs.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_r_state <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= 32'd0;
      r_rresp   <= RESP_OKAY;
    end else begin
      case (r_r_state)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_rdata   <= w_rd_data;
            r_rresp   <= w_rd_resp;
            r_rvalid  <= 1'b1;
            r_arready <= 1'b0;
            r_r_state <= R_DATA;
          end else begin
            r_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
            r_r_state <= R_IDLE;
          end
        end
        default: begin
          r_rvalid  <= 1'b0;
          r_arready <= 1'b0;
          r_r_state <= R_IDLE;
        end
      endcase
    end
  end

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_wready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = r_rresp;
  assign ctrl0_o       = r_ctrl[0];
  assign ctrl1_o       = r_ctrl[1];
  assign ctrl2_o       = r_ctrl[2];
  assign ctrl3_o       = r_ctrl[3];
  assign wr_stb_o      = r_wr_stb;

endmodule

// File: tb/tb_tracking_axi_lite_regs.sv
// Directed plus randomized bench for tracking_axi_lite_regs, checked against a
// byte-lane register model kept in the bench.
module tb_tracking_axi_lite_regs;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb, wr_stb;
  logic [1:0]  bresp, rresp;
  logic [31:0] ctrl0, ctrl1, ctrl2, ctrl3, frame_cnt;
  logic [15:0] pos_x, pos_y;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  logic [31:0] ctrl_m [4];

  always #5 clk = ~clk;

  tracking_axi_lite_regs dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .ctrl0_o(ctrl0), .ctrl1_o(ctrl1), .ctrl2_o(ctrl2), .ctrl3_o(ctrl3), .wr_stb_o(wr_stb),
    .pos_x_i(pos_x), .pos_y_i(pos_y), .frame_cnt_i(frame_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ctrl_port(input int i);
    case (i)
      0: return ctrl0;
      1: return ctrl1;
      2: return ctrl2;
      default: return ctrl3;
    endcase
  endfunction

  // Model: apply a write by byte lanes; returns expected response and strobe.
  task automatic model_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] exp_resp, output logic [3:0] exp_stb);
    int idx;
    idx = int'(addr) / 4;
    exp_resp = 2'b10;
    exp_stb  = 4'd0;
    if (idx < 4) begin
      for (int k = 0; k < 4; k++)
        if (strb[k]) ctrl_m[idx][8*k +: 8] = data[8*k +: 8];
      exp_resp = 2'b00;
      exp_stb  = 4'(1 << idx);
    end
  endtask

  function automatic logic [33:0] model_read(input logic [4:0] addr);
    int idx;
    idx = int'(addr) / 4;
    if (idx < 4) return {2'b00, ctrl_m[idx]};
    if (idx == 4) return {2'b00, pos_y, pos_x};
    if (idx == 5) return {2'b00, frame_cnt};
    return {2'b10, 32'd0};
  endfunction

  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int hold,
                           output logic [1:0] resp, output logic [3:0] stb);
    int cnt;
    bit aw_done, w_done, hs_aw, hs_w;
    logic [1:0] resp0;
    cnt = 0; aw_done = 0; w_done = 0;
    awaddr = addr; wdata = data; wstrb = strb;
    while (!(aw_done && w_done) && cnt < 100) begin
      if (!aw_done && cnt >= aw_dly) awvalid = 1'b1;
      if (!w_done && cnt >= w_dly) wvalid = 1'b1;
      hs_aw = awvalid & awready;
      hs_w  = wvalid & wready;
      @(negedge clk);
      cnt++;
      if (hs_aw) begin awvalid = 1'b0; aw_done = 1; end
      if (hs_w) begin wvalid = 1'b0; w_done = 1; end
      if (!(aw_done && w_done)) chk("bvalid_before_both_halves", 32'(bvalid), 32'd0);
    end
    awvalid = 1'b0; wvalid = 1'b0;
    chk("aw_w_handshake", 32'(aw_done && w_done), 32'd1);
    cnt = 0;
    while (!bvalid && cnt < 50) begin @(negedge clk); cnt++; end
    chk("bvalid_rise", 32'(bvalid), 32'd1);
    resp = bresp; stb = wr_stb; resp0 = bresp;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("bvalid_hold", 32'(bvalid), 32'd1);
      chk("bresp_hold", 32'(bresp), 32'(resp0));
      chk("awready_while_bvalid", 32'(awready), 32'd0);
      chk("wready_while_bvalid", 32'(wready), 32'd0);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk("bvalid_drop", 32'(bvalid), 32'd0);
    chk("awready_after_b", 32'(awready), 32'd1);
  endtask

  task automatic axi_read(input logic [4:0] addr, input int hold,
                          output logic [31:0] data, output logic [1:0] resp);
    int cnt;
    bit hs;
    logic [31:0] d0;
    cnt = 0;
    araddr = addr; arvalid = 1'b1;
    do begin hs = arready; @(negedge clk); cnt++; end while (!hs && cnt < 50);
    arvalid = 1'b0;
    chk("ar_handshake", 32'(hs), 32'd1);
    cnt = 0;
    while (!rvalid && cnt < 50) begin @(negedge clk); cnt++; end
    chk("rvalid_rise", 32'(rvalid), 32'd1);
    data = rdata; resp = rresp; d0 = rdata;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("rvalid_hold", 32'(rvalid), 32'd1);
      chk("rdata_hold", rdata, d0);
      chk("arready_while_rvalid", 32'(arready), 32'd0);
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    chk("rvalid_drop", 32'(rvalid), 32'd0);
    chk("arready_after_r", 32'(arready), 32'd1);
  endtask

  task automatic write_and_check(input string tag, input logic [4:0] addr, input logic [31:0] data,
                                 input logic [3:0] strb, input int aw_dly, input int w_dly, input int hold);
    logic [1:0] resp, eresp;
    logic [3:0] stb, estb;
    axi_write(addr, data, strb, aw_dly, w_dly, hold, resp, stb);
    model_write(addr, data, strb, eresp, estb);
    chk({tag, "_bresp"}, 32'(resp), 32'(eresp));
    chk({tag, "_wr_stb"}, 32'(stb), 32'(estb));
    for (int i = 0; i < 4; i++) chk({tag, "_ctrl_port"}, ctrl_port(i), ctrl_m[i]);
  endtask

  task automatic read_and_check(input string tag, input logic [4:0] addr, input int hold);
    logic [31:0] d;
    logic [1:0]  r;
    logic [33:0] e;
    e = model_read(addr);
    axi_read(addr, hold, d, r);
    chk({tag, "_rdata"}, d, e[31:0]);
    chk({tag, "_rresp"}, 32'(r), 32'(e[33:32]));
  endtask

  initial begin
    logic [31:0] wd [4];
    logic [31:0] old0;
    logic [33:0] e;
    rst_n = 1'b0;
    awaddr = 5'd0; awprot = 3'd0; awvalid = 1'b0; wdata = 32'd0; wstrb = 4'd0; wvalid = 1'b0;
    bready = 1'b0; araddr = 5'd0; arprot = 3'd0; arvalid = 1'b0; rready = 1'b0;
    pos_x = 16'd0; pos_y = 16'd0; frame_cnt = 32'd0;
    for (int i = 0; i < 4; i++) ctrl_m[i] = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset_awready", 32'(awready), 32'd0);
    chk("reset_wready", 32'(wready), 32'd0);
    chk("reset_arready", 32'(arready), 32'd0);
    chk("reset_bvalid", 32'(bvalid), 32'd0);
    chk("reset_rvalid", 32'(rvalid), 32'd0);
    chk("reset_resps", {28'd0, bresp, rresp}, 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_wr_stb", 32'(wr_stb), 32'd0);
    for (int i = 0; i < 4; i++) chk("reset_ctrl", ctrl_port(i), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_awready", 32'(awready), 32'd1);
    chk("post_reset_wready", 32'(wready), 32'd1);
    chk("post_reset_arready", 32'(arready), 32'd1);

    // Basic write/read-back of all control words.
    wd[0] = 32'h0101FFFF; wd[1] = 32'hABCD0001; wd[2] = 32'hDEAD0011; wd[3] = 32'hBEEF0011;
    for (int i = 0; i < 4; i++) begin
      write_and_check("t1_write", 5'(4 * i), wd[i], 4'hF, 0, 0, 0);
      read_and_check("t1_read", 5'(4 * i), 0);
      chk("t1_literal", ctrl_port(i), wd[i]);
    end

    // W leads AW, then AW leads W.
    write_and_check("t2_w_first", 5'h08, 32'h12345678, 4'hF, 3, 0, 0);
    write_and_check("t2_aw_first", 5'h0C, 32'h00000000, 4'hF, 0, 3, 0);
    chk("t2_ctrl2", ctrl2, 32'h12345678);
    chk("t2_ctrl3", ctrl3, 32'h00000000);

    // Partial byte strobes.
    write_and_check("t3_all", 5'h04, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    write_and_check("t3_strb", 5'h04, 32'h00000000, 4'b0101, 1, 0, 0);
    chk("t3_ctrl1", ctrl1, 32'hFF00FF00);
    write_and_check("t3_nostrb", 5'h04, 32'h00000000, 4'b0000, 0, 0, 0);

    // Status words and unmapped/RO accesses.
    pos_x = 16'h0040; pos_y = 16'h0020; frame_cnt = 32'd7;
    read_and_check("t4_pos", 5'h10, 0);
    read_and_check("t4_frame", 5'h14, 0);
    write_and_check("t4_ro_write", 5'h10, 32'hCAFEF00D, 4'hF, 0, 0, 0);
    read_and_check("t4_unmapped", 5'h18, 0);
    e = model_read(5'h10);
    chk("t4_pos_literal", e[31:0], 32'h00200040);

    // Read and write commit on the same edge to ctrl0: read returns the old value.
    old0 = ctrl_m[0];
    awaddr = 5'h00; wdata = 32'h5A5AA5A5; wstrb = 4'hF; araddr = 5'h00;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("sim_rvalid", 32'(rvalid), 32'd1);
    chk("sim_rdata_old", rdata, old0);
    chk("sim_bvalid", 32'(bvalid), 32'd1);
    ctrl_m[0] = 32'h5A5AA5A5;
    bready = 1'b1; rready = 1'b1;
    @(negedge clk);
    bready = 1'b0; rready = 1'b0;
    chk("sim_ctrl0_new", ctrl0, 32'h5A5AA5A5);

    // Backpressure on B and R.
    write_and_check("t5_bhold", 5'h08, 32'h0BADBEEF, 4'hF, 0, 0, 10);
    read_and_check("t5_rhold", 5'h08, 10);

    // Randomized traffic against the model.
    for (int n = 0; n < 60; n++) begin
      logic [4:0] a;
      a = 5'($urandom_range(31, 0));
      pos_x = 16'($urandom); pos_y = 16'($urandom); frame_cnt = $urandom;
      if ($urandom_range(1, 0) == 1)
        write_and_check("rnd_write", a, $urandom, 4'($urandom_range(15, 0)),
                        int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), int'($urandom_range(2, 0)));
      else
        read_and_check("rnd_read", a, int'($urandom_range(2, 0)));
    end

    // Reset in the middle of a write with AW buffered and W pending.
    awaddr = 5'h04; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_awready", 32'(awready), 32'd0);
    chk("t6_wready", 32'(wready), 32'd0);
    chk("t6_arready", 32'(arready), 32'd0);
    chk("t6_bvalid", 32'(bvalid), 32'd0);
    chk("t6_rvalid", 32'(rvalid), 32'd0);
    chk("t6_rdata", rdata, 32'd0);
    for (int i = 0; i < 4; i++) chk("t6_ctrl", ctrl_port(i), 32'd0);
    for (int i = 0; i < 4; i++) ctrl_m[i] = 32'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_awready_release", 32'(awready), 32'd1);
    write_and_check("t6_write", 5'h0C, 32'h600DF00D, 4'hF, 2, 0, 0);
    read_and_check("t6_read", 5'h04, 0);
    read_and_check("t6_read3", 5'h0C, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
